// File: rtl/io_input_sequencer.sv
// ---------------------------------------------------------------------------
// io_input_sequencer
//
// Operand entry front-end for the memory-mapped IO path. Two enter buttons are
// debounced by identical FSMs; each confirmed press loads the 8-bit switch
// value into operand register A or B and raises that operand's valid flag.
// The CPU polls the flags through a status word, and a read of an operand
// clears its flag. CPU stores to the LED address update a 24-bit LED register.
//
// Optional build macro: IO_BTN_SYNC_EN
//   defined   -> each button passes through a 2-flop synchronizer before its
//                FSM (press-to-capture latency DEBOUNCE_CYCLES+3 edges)
//   undefined -> raw buttons drive the FSMs (latency DEBOUNCE_CYCLES+1 edges)
//
// Ports:
//   clock     in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   sw_in     in   8  operand switches (not synchronized; must be stable at
//                     the moment a press is confirmed)
//   test_sw   in   3  test-case select switches
//   btn_a     in   1  enter-A button, raw, active-high
//   btn_b     in   1  enter-B button, raw, active-high
//   io_read   in   1  CPU IO load strobe
//   io_write  in   1  CPU IO store strobe
//   addr      in  32  CPU IO address
//   wdata     in  32  CPU store data
//   rdata     out 32  IO read data (combinational, 0 when io_read=0)
//   led_out   out 24  LED register
//   a_valid   out  1  operand A captured and not yet read
//   b_valid   out  1  operand B captured and not yet read
// ---------------------------------------------------------------------------

`ifndef IO_A_ADDR
`define IO_A_ADDR      32'h0000_FF00
`endif
`ifndef IO_B_ADDR
`define IO_B_ADDR      32'h0000_FF04
`endif
`ifndef IO_TEST_ADDR
`define IO_TEST_ADDR   32'h0000_FF08
`endif
`ifndef IO_STATUS_ADDR
`define IO_STATUS_ADDR 32'h0000_FF0C
`endif
`ifndef IO_LED_ADDR
`define IO_LED_ADDR    32'h0000_FF10
`endif

module io_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [7:0]  sw_in,
    input  logic [2:0]  test_sw,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [23:0] led_out,
    output logic        a_valid,
    output logic        b_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_REL_WAIT
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] w_btn_raw;
    logic [1:0] w_btn;
    logic [1:0] w_capture;

    assign w_btn_raw = {btn_b, btn_a};

`ifdef IO_BTN_SYNC_EN
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn = r_sync2;
`else
    assign w_btn = w_btn_raw;
`endif

    // Index 0 is button A, index 1 is button B.
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        db_state_t        r_state;
        db_state_t        w_state_next;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;
        logic             w_cap;

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
            w_cap        = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_btn[gi]) w_state_next = S_PRESS_WAIT;
                end
                S_PRESS_WAIT: begin
                    if (!w_btn[gi]) begin
                        w_state_next = S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        // Press confirmed: the capture is a Mealy pulse so the
                        // operand loads on the same edge the FSM enters HELD.
                        w_state_next = S_HELD;
                        w_cap        = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!w_btn[gi]) w_state_next = S_REL_WAIT;
                end
                S_REL_WAIT: begin
                    if (w_btn[gi]) begin
                        w_state_next = S_HELD;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
            // Every state change restarts the stability count.
            if (w_state_next != r_state) w_cnt_next = '0;
        end

        assign w_capture[gi] = w_cap;
    end

    logic        w_rd_a;
    logic        w_rd_b;
    logic        w_wr_led;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_a_valid;
    logic        r_b_valid;
    logic [23:0] r_led;
    logic        w_unused_wdata;

    assign w_rd_a         = io_read  && (addr == `IO_A_ADDR);
    assign w_rd_b         = io_read  && (addr == `IO_B_ADDR);
    assign w_wr_led       = io_write && (addr == `IO_LED_ADDR);
    assign w_unused_wdata = ^wdata[31:24];

    // A capture takes priority over a same-cycle read clear, so a press that
    // lands on the read edge is never lost.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_led     <= 24'h0;
        end else begin
            if (w_capture[0]) begin
                r_a       <= sw_in;
                r_a_valid <= 1'b1;
            end else if (w_rd_a) begin
                r_a_valid <= 1'b0;
            end
            if (w_capture[1]) begin
                r_b       <= sw_in;
                r_b_valid <= 1'b1;
            end else if (w_rd_b) begin
                r_b_valid <= 1'b0;
            end
            if (w_wr_led) r_led <= wdata[23:0];
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (io_read) begin
            case (addr)
                `IO_A_ADDR:      rdata = {24'h0, r_a};
                `IO_B_ADDR:      rdata = {24'h0, r_b};
                `IO_TEST_ADDR:   rdata = {29'h0, test_sw};
                `IO_STATUS_ADDR: rdata = {30'h0, r_b_valid, r_a_valid};
                default:         rdata = 32'h0;
            endcase
        end
    end

    assign led_out = r_led;
    assign a_valid = r_a_valid;
    assign b_valid = r_b_valid;

endmodule

// File: doc/io_input_sequencer.md
Name: io_input_sequencer

Overview:
- Sequences operand entry for the memory-mapped IO path.
- Debounces the two enter buttons with a per-button FSM and captures the 8-bit switch value into operand register A or B on each confirmed press.
- Keeps a per-operand valid flag so the CPU can poll, and clears it when the CPU reads the operand.
- Registers the 24-bit LED output on CPU IO writes; sits between board pins and the CPU load/store IO decode.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles needed to accept a press or release (10 ms at 100 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw_in  in  8  operand switches.
- test_sw  in  3  test-case select switches.
- btn_a  in  1  enter-A button, raw, active-high.
- btn_b  in  1  enter-B button, raw, active-high.
- io_read  in  1  CPU IO load strobe, one cycle per access.
- io_write  in  1  CPU IO store strobe.
- addr  in  32  CPU ALU address.
- wdata  in  32  CPU store data.
- rdata  out  32  IO read data, combinational.
- led_out  out  24  LED register.
- a_valid  out  1  operand A captured and not yet read.
- b_valid  out  1  operand B captured and not yet read.

Behaviour:
- Reset: A/B regs 0, led_out 0, a_valid/b_valid 0, both FSMs IDLE, counters 0.
- One debounce FSM per button, identical. Counter resets to 0 on every state change.
  - IDLE: btn=1 -> PRESS_WAIT.
  - PRESS_WAIT: btn=0 -> IDLE; counter reaches DEBOUNCE_CYCLES-1 with btn=1 -> HELD, and assert a one-cycle capture pulse.
  - HELD: btn=0 -> REL_WAIT.
  - REL_WAIT: btn=1 -> HELD; counter reaches DEBOUNCE_CYCLES-1 with btn=0 -> IDLE.
- Exactly one capture per press, however long the button is held. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Capture: on the pulse edge, the operand reg takes sw_in as sampled that cycle, and its valid flag is set.
- Latency: press stable from cycle 0 -> register/valid updated at edge DEBOUNCE_CYCLES+1 (one cycle to enter PRESS_WAIT, DEBOUNCE_CYCLES to count).
- Read decode, combinational, when io_read=1:
  - `IO_A_ADDR` -> {24'b0,A}
  - `IO_B_ADDR` -> {24'b0,B}
  - `IO_TEST_ADDR` -> {29'b0,test_sw}
  - `IO_STATUS_ADDR` -> {30'b0,b_valid,a_valid}
  - else 0. rdata is 0 whenever io_read=0.
- Valid clear: io_read at `IO_A_ADDR` clears a_valid at the next edge; the same for B. Reading status or test does not clear either flag.
- Simultaneous capture and read of the same operand: the capture wins. The register gets the new sw_in, the valid flag stays 1, and the read returns the old value.
- Simultaneous captures on A and B in one cycle: both are taken, and the FSMs run independently.
- Write: io_write=1 at `IO_LED_ADDR` -> led_out <= wdata[23:0] at the edge. Writes to any other address are ignored, and led_out holds its value.
- io_read and io_write both high: both actions take effect independently.
- Reset asserted mid-debounce: the FSM returns to IDLE immediately. A button still held after reset release needs a full fresh debounce, so capture happens once.
- `IO_STATUS_ADDR` and `IO_LED_ADDR` are new entries in includes/defines.v, next to the existing IO addresses.

Optional Feature:
- Macro: IO_BTN_SYNC_EN.
- Defined: btn_a and btn_b each pass through a 2-flop synchronizer reset to 0 before their FSM. Latency becomes DEBOUNCE_CYCLES+3.
- Undefined: raw buttons drive the FSMs directly, and latency is DEBOUNCE_CYCLES+1.
- sw_in is never synchronized. It is required stable whenever a press is confirmed.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and the macro undefined.
1. Reset, then read A, B, status and LED -> all 0. led_out=0.
2. sw_in=8'h5A, btn_a high 20 cycles then low -> A=8'h5A and a_valid=1 at the edge 5 cycles after the rise; exactly one capture; read `IO_A_ADDR` returns 32'h5A, and a_valid=0 the next cycle.
3. btn_b pulses of 1, 2 and 3 cycles separated by 3 low cycles -> b_valid stays 0 and B stays 0.
4. sw_in=8'h11, press A; then sw_in=8'h22, a second press whose capture edge coincides with an io_read at `IO_A_ADDR` -> read returns 32'h11, then A=8'h22 with a_valid=1.
5. io_write at `IO_LED_ADDR` with wdata=32'hFFABCDEF -> led_out=24'hABCDEF. io_write at `IO_A_ADDR` with 32'h1 -> led_out unchanged. test_sw=3'b101 read at `IO_TEST_ADDR` -> 32'h5.
6. btn_a held; rst_n pulsed low for 1 cycle in PRESS_WAIT at count 2 -> no capture. Button kept high after reset -> capture 5 cycles after rst_n rises, then no further capture.
